flash_host_ctrl: RTL and testbench

//  Clocked initiator for the 64K x 8 async flash core command protocol.
//  - Converts a single-cycle host request (read or write one byte) into the flash bus sequence:
//    - three unlock/command bus writes, then
//    - a data bus write, or an nRE read strobe.
//  - Sits between the system bus and the flash core; it is the only master of nEN/nRE/nWE/Addr/IO.

---
 rtl/flash_ctrl_pkg.sv | 40 ++++
 rtl/flash_host_ctrl_if.sv | 15 +
 rtl/flash_phase_timer.sv | 22 ++
 rtl/flash_host_ctrl.sv | 160 ++++++++++++++++
 tb/tb_flash_host_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared constants, state encoding and bus-write pair table for the flash host controller.
package flash_ctrl_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BW_W   = 2;

  localparam logic [ADDR_W-1:0] UNLOCK1_ADDR = 16'h5555;
  localparam logic [DATA_W-1:0] UNLOCK1_DATA = 8'hAA;
  localparam logic [ADDR_W-1:0] UNLOCK2_ADDR = 16'hAAAA;
  localparam logic [DATA_W-1:0] UNLOCK2_DATA = 8'h55;
  localparam logic [ADDR_W-1:0] CMD_ADDR     = 16'h5555;
  localparam logic [DATA_W-1:0] OP_READ      = 8'h10;
  localparam logic [DATA_W-1:0] OP_WRITE     = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WLOW, S_WHOLD, S_RSETUP, S_RWAIT, S_RCAP, S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_pair_t;

  // Address/data presented on bus write number bw of the command sequence.
  function automatic bus_pair_t bw_pair(input logic [BW_W-1:0]   bw,
                                        input logic              rw,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    bus_pair_t p;
    case (bw)
      2'd0:    begin p.addr = UNLOCK1_ADDR; p.data = UNLOCK1_DATA; end
      2'd1:    begin p.addr = UNLOCK2_ADDR; p.data = UNLOCK2_DATA; end
      2'd2:    begin p.addr = CMD_ADDR;     p.data = rw ? OP_WRITE : OP_READ; end
      default: begin p.addr = addr;         p.data = wdata; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/flash_host_ctrl_if.sv
// Host-side request/response bundle of the flash host controller.
interface flash_host_ctrl_if;
  import flash_ctrl_pkg::*;

  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input req, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/flash_phase_timer.sv
// Loadable down-counter timing the nWE-low and nRE-wait phases.
module flash_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nReset)              cnt_q <= '0;
    else if (load)            cnt_q <= load_val;
    else if (cnt_q != '0)     cnt_q <= cnt_q - W'(1);
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/flash_host_ctrl.sv
// Turns one host byte request into the unlock/command/data sequence on the async flash bus.
// Every flash pin is a flop loaded from the next-state decode, so req never reaches a pin combinationally.
module flash_host_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned T_WE  = 2,
  parameter int unsigned T_ACC = 2
) (
  input  logic              clk,
  input  logic              nReset,
  flash_host_ctrl_if.slave  host,
  output logic              nEN,
  output logic              nRE,
  output logic              nWE,
  output logic [ADDR_W-1:0] faddr,
  inout  wire  [DATA_W-1:0] fio
);

  localparam int unsigned T_MAX = (T_WE > T_ACC) ? T_WE : T_ACC;
  localparam int unsigned PH_W  = $clog2(T_MAX + 1);

  state_e            state_q, state_d;
  logic [BW_W-1:0]   bw_q, bw_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              io_oe_q, io_oe_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              nen_d, nre_d, nwe_d;
  logic [ADDR_W-1:0] faddr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tmr_load_c, tmr_expired_c;
  logic [PH_W-1:0]   tmr_val_c;
  bus_pair_t         pair_c;

  flash_phase_timer #(.W(PH_W)) u_timer (
    .clk       (clk),
    .nReset    (nReset),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      bw_q     <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      io_oe_q  <= 1'b0;
      io_out_q <= '0;
      nEN      <= 1'b1;
      nRE      <= 1'b1;
      nWE      <= 1'b1;
      faddr    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bw_q     <= bw_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      io_oe_q  <= io_oe_d;
      io_out_q <= io_out_d;
      nEN      <= nen_d;
      nRE      <= nre_d;
      nWE      <= nwe_d;
      faddr    <= faddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bw_d       = bw_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (host.req) begin
          state_d = S_WSETUP;
          bw_d    = '0;
          rw_d    = host.rw;
          addr_d  = host.addr;
          wdata_d = host.wdata;
        end
      end
      S_WSETUP: begin
        state_d    = S_WLOW;
        tmr_load_c = 1'b1;
        tmr_val_c  = PH_W'(T_WE - 1);
      end
      S_WLOW: if (tmr_expired_c) state_d = S_WHOLD;
      S_WHOLD: begin
        bw_d = bw_q + 2'd1;
        if (bw_q == 2'd3)                state_d = S_DONE;
        else if (bw_q == 2'd2 && !rw_q)  state_d = S_RSETUP;
        else                             state_d = S_WSETUP;
      end
      S_RSETUP: begin
        state_d    = S_RWAIT;
        tmr_load_c = 1'b1;
        tmr_val_c  = PH_W'(T_ACC - 1);
      end
      S_RWAIT: if (tmr_expired_c) state_d = S_RCAP;
      S_RCAP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values for the cycle we are about to enter.
    pair_c   = bw_pair(bw_d, rw_d, addr_d, wdata_d);
    nen_d    = 1'b1;
    nre_d    = 1'b1;
    nwe_d    = 1'b1;
    io_oe_d  = 1'b0;
    faddr_d  = faddr;
    io_out_d = io_out_q;

    case (state_d)
      S_WSETUP, S_WLOW, S_WHOLD: begin
        nen_d    = 1'b0;
        nwe_d    = (state_d != S_WLOW);
        io_oe_d  = 1'b1;
        faddr_d  = pair_c.addr;
        io_out_d = pair_c.data;
      end
      S_RSETUP: begin
        nen_d   = 1'b0;
        faddr_d = addr_d;
      end
      S_RWAIT, S_RCAP: begin
        nen_d   = 1'b0;
        nre_d   = 1'b0;
        faddr_d = addr_d;
      end
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rdata_d = (state_q == S_RCAP) ? fio : rdata_q;
  end

  assign fio       = io_oe_q ? io_out_q : 8'hzz;
  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.rdata = rdata_q;

endmodule

// File: tb/tb_flash_host_ctrl.sv
// Randomized scoreboard bench for flash_host_ctrl with a behavioural flash core and bus protocol monitor.
module tb_flash_host_ctrl;

  localparam int unsigned T_WE  = 2;
  localparam int unsigned T_ACC = 2;
  localparam int unsigned LAT_W = 4 * (T_WE + 2);
  localparam int unsigned LAT_R = 3 * (T_WE + 2) + T_ACC + 2;

  logic        clk = 1'b0;
  logic        nReset;
  logic        nEN, nRE, nWE;
  logic [15:0] faddr;
  wire  [7:0]  fio;

  always #5 clk = ~clk;

  flash_host_ctrl_if hif();

  flash_host_ctrl #(.T_WE(T_WE), .T_ACC(T_ACC)) dut (
    .clk    (clk),
    .nReset (nReset),
    .host   (hif),
    .nEN    (nEN),
    .nRE    (nRE),
    .nWE    (nWE),
    .faddr  (faddr),
    .fio    (fio)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  int          issued = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- flash core model ----------------
  logic [7:0] core_mem [0:65535];
  int         core_step = 0;
  bit         read_armed = 1'b0;
  bit         prog_armed = 1'b0;

  typedef struct { logic [15:0] a; logic [7:0] d; } bw_t;
  bw_t bus_log[$];

  assign fio = (!nEN && !nRE) ? (read_armed ? core_mem[faddr] : 8'h00) : 8'hzz;

  task automatic core_write(input logic [15:0] a, input logic [7:0] d);
    if (prog_armed) begin
      core_mem[a] = d;
      prog_armed  = 1'b0;
      core_step   = 0;
    end else if (core_step == 2 && a == 16'h5555 && (d == 8'h20 || d == 8'h10)) begin
      prog_armed = (d == 8'h20);
      read_armed = (d == 8'h10);
      core_step  = 0;
    end else if (core_step == 1 && a == 16'hAAAA && d == 8'h55) begin
      core_step = 2;
    end else begin
      core_step = (a == 16'h5555 && d == 8'hAA) ? 1 : 0;
    end
  endtask

  // ---------------- protocol monitor + core bus capture ----------------
  logic        pnwe = 1'b1, pnen = 1'b1;
  logic [15:0] pfaddr = '0;
  logic [7:0]  pfio = '0;
  int          nre_run = 0;

  always @(negedge clk) begin
    if (nReset) begin
      check("nre_nwe_overlap", {31'd0, nRE | nWE}, 32'd1);
      if (!nRE || !nWE) check("nen_during_strobe", {31'd0, nEN}, 32'd0);
      if (hif.busy && !hif.done && !pnen) check("nen_glitch", {31'd0, nEN}, 32'd0);
      if (!pnwe && nWE) begin
        check("faddr_stable_nwe_rise", {16'd0, faddr}, {16'd0, pfaddr});
        check("fio_stable_nwe_rise", {24'd0, fio}, {24'd0, pfio});
        if (!nEN) begin
          bus_log.push_back('{a: faddr, d: fio});
          core_write(faddr, fio);
        end
      end
      if (!nRE) nre_run++;
      else if (nre_run > 0) begin
        check("nre_low_cycles", nre_run, T_ACC + 1);
        nre_run = 0;
      end
    end else begin
      nre_run = 0;
    end
    if (!nWE) begin
      pfaddr = faddr;
      pfio   = fio;
    end
    if (nEN) begin
      core_step  = 0;
      read_armed = 1'b0;
      prog_armed = 1'b0;
    end
    pnwe = nWE;
    pnen = nEN;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  data;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  logic [7:0]  ref_mem [logic [15:0]];
  int unsigned done_cyc[$];
  logic        pdone = 1'b0;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (hif.done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      check("done_width", {31'd0, pdone}, 32'd0);
      check("busy_with_done", {31'd0, hif.busy}, 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done seen with no pending transaction at cycle %0d", cyc);
      end else begin
        e_mon = exp_q.pop_front();
        if (!e_mon.rw) check("rdata", {24'd0, hif.rdata}, {24'd0, e_mon.data});
        check("latency", cyc - e_mon.acc, e_mon.rw ? LAT_W : LAT_R);
      end
    end
    pdone = hif.done;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit rw, input logic [15:0] a, input logic [7:0] d, input bit keep);
    int n = 0;
    while (hif.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (hif.busy) begin
      timeout_fail("issue_wait_idle");
      return;
    end
    hif.req   = 1'b1;
    hif.rw    = rw;
    hif.addr  = a;
    hif.wdata = d;
    @(posedge clk);
    #1;
    exp_q.push_back('{rw: rw, addr: a, data: (rw ? d : ref_rd(a)), acc: cyc});
    if (rw) ref_mem[a] = d;
    issued++;
    check("busy_after_accept", {31'd0, hif.busy}, 32'd1);
    @(negedge clk);
    if (!keep) hif.req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || hif.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || hif.busy) timeout_fail("wait_idle");
  endtask

  initial begin
    int n;
    int falls;
    int base;
    logic pw;

    for (int i = 0; i < 65536; i++) core_mem[i] = 8'hFF;
    nReset    = 1'b0;
    hif.req   = 1'b0;
    hif.rw    = 1'b0;
    hif.addr  = '0;
    hif.wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_nEN", {31'd0, nEN}, 32'd1);
    check("rst_nRE", {31'd0, nRE}, 32'd1);
    check("rst_nWE", {31'd0, nWE}, 32'd1);
    check("rst_faddr", {16'd0, faddr}, 32'd0);
    check("rst_busy", {31'd0, hif.busy}, 32'd0);
    check("rst_done", {31'd0, hif.done}, 32'd0);
    check("rst_rdata", {24'd0, hif.rdata}, 32'd0);
    nReset = 1'b1;

    // Write then read back.
    issue(1'b1, 16'h1234, 8'h5A, 1'b0);
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    wait_idle();

    // Read of erased location, with the bus command sequence logged.
    bus_log.delete();
    issue(1'b0, 16'h00FF, 8'h00, 1'b0);
    wait_idle();
    check("rd_log_len", bus_log.size(), 3);
    if (bus_log.size() == 3) begin
      check("rd_bw0", {8'd0, bus_log[0].a, bus_log[0].d}, 32'h5555AA);
      check("rd_bw1", {8'd0, bus_log[1].a, bus_log[1].d}, 32'hAAAA55);
      check("rd_bw2", {8'd0, bus_log[2].a, bus_log[2].d}, 32'h555510);
    end

    // Back-to-back writes with req held high; inputs change while first is busy.
    base = done_cyc.size();
    issue(1'b1, 16'h0001, 8'h11, 1'b1);
    hif.addr  = 16'h0002;
    hif.wdata = 8'h22;
    issue(1'b1, 16'h0002, 8'h22, 1'b0);
    wait_idle();
    check("b2b_dones", done_cyc.size() - base, 2);
    if (done_cyc.size() - base == 2)
      check("b2b_gap", done_cyc[base+1] - done_cyc[base], LAT_W + 2);
    issue(1'b0, 16'h0001, 8'h00, 1'b0);
    issue(1'b0, 16'h0002, 8'h00, 1'b0);
    wait_idle();

    // req pulsed with scrambled inputs while busy must be ignored.
    base = done_cnt;
    issue(1'b1, 16'h0100, 8'h77, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hif.req   = i[0];
      hif.rw    = 1'($urandom_range(0, 1));
      hif.addr  = 16'($urandom);
      hif.wdata = 8'($urandom);
      @(negedge clk);
    end
    hif.req = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("busy_req_ignored", done_cnt - base, 1);
    issue(1'b0, 16'h0100, 8'h00, 1'b0);
    wait_idle();

    // Reset during nWE-low of bus write 1 aborts the write.
    hif.req   = 1'b1;
    hif.rw    = 1'b1;
    hif.addr  = 16'h0300;
    hif.wdata = 8'h99;
    @(negedge clk);
    hif.req = 1'b0;
    n = 0;
    falls = 0;
    pw = nWE;
    while (falls < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (pw && !nWE) falls++;
      pw = nWE;
    end
    if (falls < 2) timeout_fail("abort_find_wlow");
    nReset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_nEN", {31'd0, nEN}, 32'd1);
    check("abort_nWE", {31'd0, nWE}, 32'd1);
    check("abort_nRE", {31'd0, nRE}, 32'd1);
    check("abort_faddr", {16'd0, faddr}, 32'd0);
    check("abort_busy", {31'd0, hif.busy}, 32'd0);
    check("abort_done", {31'd0, hif.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    issue(1'b0, 16'h0300, 8'h00, 1'b0);
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    wait_idle();

    // Randomized mix over a small hot address set plus full-range addresses.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    check("done_total", done_cnt, issued);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
